reg_writeback: RTL and testbench



---
 rtl/reg_writeback.sv | 185 ++++++++++++++++++
 tb/tb_reg_writeback.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: drives the register file's single registered write port.
// ALU results and in-order load responses share the port; ALU traffic wins
// unless a buffered load has been starved for STARVE_LIMIT cycles. A per-
// register pending-load count feeds the decode RAW stall together with the
// write currently held on WE3/AD3.
module reg_writeback #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PEND_DEPTH     = 4,   // power of 2
  parameter int LDBUF_DEPTH    = 2,   // power of 2
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      ld_issue,
  input  logic [REG_ADDR_WIDTH-1:0] ld_issue_rd,
  output logic                      ld_issue_ready,
  input  logic                      ld_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     ld_rsp_data,
  output logic                      ld_rsp_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic                      stall,
  output logic                      err,
  output logic                      WE3,
  output logic [REG_ADDR_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]     WD3
);

  localparam int NUM_REGS   = 1 << REG_ADDR_WIDTH;
  localparam int PEND_PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int PEND_CNT_W = $clog2(PEND_DEPTH + 1);
  localparam int BUF_PTR_W  = (LDBUF_DEPTH > 1) ? $clog2(LDBUF_DEPTH) : 1;
  localparam int BUF_CNT_W  = $clog2(LDBUF_DEPTH + 1);
  localparam int RCNT_W     = $clog2(PEND_DEPTH + 1);
  localparam int STARVE_W   = $clog2(STARVE_LIMIT + 1);

  // Pending-rd FIFO: destination of every accepted, not yet drained load.
  logic [REG_ADDR_WIDTH-1:0] pend_mem [PEND_DEPTH];
  logic [PEND_PTR_W-1:0]     pend_wr_ptr, pend_rd_ptr;
  logic [PEND_CNT_W-1:0]     pend_count;

  // Load data buffer: responses waiting for a free write-port cycle.
  logic [DATA_WIDTH-1:0]     buf_mem [LDBUF_DEPTH];
  logic [BUF_PTR_W-1:0]      buf_wr_ptr, buf_rd_ptr;
  logic [BUF_CNT_W-1:0]      buf_count;

  logic [RCNT_W-1:0]         rd_pend [NUM_REGS];
  logic [STARVE_W-1:0]       starve_cnt;

  logic                      issue_fire, rsp_fire, rsp_push, awaiting_data;
  logic                      alu_fire, ld_drain;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0]     head_data;
  logic [NUM_REGS-1:0]       issue_hit, drain_hit;
  logic                      rs1_hazard, rs2_hazard;

  assign ld_issue_ready = (pend_count != PEND_CNT_W'(PEND_DEPTH));
  assign ld_rsp_ready   = (buf_count != BUF_CNT_W'(LDBUF_DEPTH));
  assign alu_ready      = (starve_cnt < STARVE_W'(STARVE_LIMIT));

  assign issue_fire     = ld_issue && ld_issue_ready;
  assign rsp_fire       = ld_rsp_valid && ld_rsp_ready;
  // A response is only legal if some issued load has not yet got its data.
  assign awaiting_data  = int'(pend_count) > int'(buf_count);
  assign rsp_push       = rsp_fire && awaiting_data;

  // ALU wins the port whenever it is allowed to; otherwise a buffered load drains.
  assign alu_fire       = alu_valid && alu_ready;
  assign ld_drain       = !alu_fire && (buf_count != '0);

  assign head_rd        = pend_mem[pend_rd_ptr];
  assign head_data      = buf_mem[buf_rd_ptr];

  // One-hot views of which register gains / loses a pending load this cycle.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    issue_hit = '0;
    drain_hit = '0;
    if (issue_fire) issue_hit[ld_issue_rd] = 1'b1;
    if (ld_drain)   drain_hit[head_rd]     = 1'b1;
  end

  // Storage arrays of both FIFOs.
  // NOTE: the data arrays are deliberately not reset; an entry is only read
  // once the FIFO counts mark it valid, and the counts are reset.
  always_ff @(posedge clk) begin
    if (issue_fire) pend_mem[pend_wr_ptr] <= ld_issue_rd;
    if (rsp_push)   buf_mem[buf_wr_ptr]   <= ld_rsp_data;
  end

  // FIFO pointers and occupancy counts.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr_ptr <= '0;
      pend_rd_ptr <= '0;
      pend_count  <= '0;
      buf_wr_ptr  <= '0;
      buf_rd_ptr  <= '0;
      buf_count   <= '0;
    end else begin
      if (issue_fire) pend_wr_ptr <= pend_wr_ptr + PEND_PTR_W'(1);
      if (ld_drain)   pend_rd_ptr <= pend_rd_ptr + PEND_PTR_W'(1);
      case ({issue_fire, ld_drain})
        2'b10:   pend_count <= pend_count + PEND_CNT_W'(1);
        2'b01:   pend_count <= pend_count - PEND_CNT_W'(1);
        default: ;
      endcase
      if (rsp_push) buf_wr_ptr <= buf_wr_ptr + BUF_PTR_W'(1);
      if (ld_drain) buf_rd_ptr <= buf_rd_ptr + BUF_PTR_W'(1);
      case ({rsp_push, ld_drain})
        2'b10:   buf_count <= buf_count + BUF_CNT_W'(1);
        2'b01:   buf_count <= buf_count - BUF_CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Per-register pending-load counts; issue and drain of the same rd cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) rd_pend[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        case ({issue_hit[r], drain_hit[r]})
          2'b10:   rd_pend[r] <= rd_pend[r] + RCNT_W'(1);
          2'b01:   rd_pend[r] <= rd_pend[r] - RCNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Starvation counter: cycles a waiting load has lost to the ALU in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((buf_count != '0) && alu_fire) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Registered write port; x0 writes consume their entry with WE3 low.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else if (alu_fire) begin
      WE3 <= (alu_rd != '0);
      AD3 <= alu_rd;
      WD3 <= alu_data;
    end else if (ld_drain) begin
      WE3 <= (head_rd != '0);
      AD3 <= head_rd;
      WD3 <= head_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  // Sticky protocol error: issue while full, or data nobody is waiting for.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((ld_issue && !ld_issue_ready) || (rsp_fire && !awaiting_data)) begin
      err <= 1'b1;
    end
  end

  // RAW stall: an outstanding load, or the write sitting on the port this cycle.
  assign rs1_hazard = (rs1 != '0) && ((rd_pend[rs1] != '0) || (WE3 && (AD3 == rs1)));
  assign rs2_hazard = (rs2 != '0) && ((rd_pend[rs2] != '0) || (WE3 && (AD3 == rs2)));
  assign stall      = rs1_hazard || rs2_hazard;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: a queue-based model of the write-side rules is
// checked against the DUT every cycle, and directed scenarios pin key values.
module tb_reg_writeback;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_issue, ld_issue_ready;
  logic [AW-1:0] ld_issue_rd;
  logic          ld_rsp_valid, ld_rsp_ready;
  logic [DW-1:0] ld_rsp_data;
  logic [AW-1:0] rs1, rs2;
  logic          stall, err, WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_ready(ld_rsp_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall), .err(err),
    .WE3(WE3), .AD3(AD3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            pend_q[$];     // destinations of loads not yet written back
  logic [DW-1:0] buf_q[$];      // returned load data waiting for the port
  int            starve;
  bit            m_err, m_we;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  bit            model_ok = 1'b0;

  function automatic int pend_of(input logic [AW-1:0] r);
    int n = 0;
    foreach (pend_q[i]) if (pend_q[i] == int'(r)) n++;
    return n;
  endfunction

  function automatic bit hazard(input logic [AW-1:0] r);
    return (r != 0) && ((pend_of(r) > 0) || (m_we && (m_ad == r)));
  endfunction

  always @(posedge clk) begin : model_update
    bit afire, drain, issue_ok, rsp_ok;
    int outstanding, buf_before, rd;
    if (rst) begin
      pend_q.delete();
      buf_q.delete();
      starve   = 0;
      m_err    = 1'b0;
      m_we     = 1'b0;
      m_ad     = '0;
      m_wd     = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      afire       = alu_valid && (starve < 3);
      buf_before  = buf_q.size();
      outstanding = pend_q.size() - buf_q.size();
      issue_ok    = ld_issue && (pend_q.size() < 4);
      rsp_ok      = ld_rsp_valid && (buf_q.size() < 2);
      drain       = !afire && (buf_before > 0);
      if (afire) begin
        m_we = (alu_rd != 0);
        m_ad = alu_rd;
        m_wd = alu_data;
      end else if (drain) begin
        rd   = pend_q.pop_front();
        m_we = (rd != 0);
        m_ad = AW'(rd);
        m_wd = buf_q.pop_front();
      end else begin
        m_we = 1'b0;
      end
      starve = (buf_before > 0 && afire) ? starve + 1 : 0;
      if (ld_issue && !issue_ok) m_err = 1'b1;
      if (issue_ok) pend_q.push_back(int'(ld_issue_rd));
      if (rsp_ok) begin
        if (outstanding > 0) buf_q.push_back(ld_rsp_data);
        else m_err = 1'b1;
      end
    end
  end

  // Compare every cycle, on the falling edge, once the model is defined.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cmp_WE3",            32'(WE3),            32'(m_we));
      check("cmp_AD3",            32'(AD3),            32'(m_ad));
      check("cmp_WD3",            WD3,                 m_wd);
      check("cmp_err",            32'(err),            32'(m_err));
      check("cmp_alu_ready",      32'(alu_ready),      32'(starve < 3));
      check("cmp_ld_issue_ready", 32'(ld_issue_ready), 32'(pend_q.size() < 4));
      check("cmp_ld_rsp_ready",   32'(ld_rsp_ready),   32'(buf_q.size() < 2));
      check("cmp_stall",          32'(stall),          32'(hazard(rs1) || hazard(rs2)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0; ld_rsp_valid = 1'b0; ld_rsp_data = '0;
    rs1 = '0; rs2 = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset with WE3 high beforehand.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55;
    tick();
    check("pre_rst_WE3", 32'(WE3), 32'd1);
    alu_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_WE3", 32'(WE3), 32'd0);
    check("rst_AD3", 32'(AD3), 32'd0);
    check("rst_WD3", WD3, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_issue_ready", 32'(ld_issue_ready), 32'd1);
    check("rst_rsp_ready", 32'(ld_rsp_ready), 32'd1);

    // ALU write x5 = 0xAA, then in-flight stall.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    tick();
    alu_valid = 1'b0; rs1 = 5'd5;
    #1;
    check("alu_WE3", 32'(WE3), 32'd1);
    check("alu_AD3", 32'(AD3), 32'd5);
    check("alu_WD3", WD3, 32'hAA);
    check("alu_inflight_stall", 32'(stall), 32'd1);
    tick();
    check("alu_after_stall", 32'(stall), 32'd0);
    rs1 = '0;

    // Loads to x7 and x0.
    rs2 = 5'd7;
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    tick();
    check("ld7_issued_stall", 32'(stall), 32'd1);
    ld_issue_rd = 5'd0;
    tick();
    ld_issue = 1'b0;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h11;
    tick();
    check("ld7_buffered_stall", 32'(stall), 32'd1);
    ld_rsp_data = 32'h22;
    tick();
    ld_rsp_valid = 1'b0;
    check("ld7_WE3", 32'(WE3), 32'd1);
    check("ld7_AD3", 32'(AD3), 32'd7);
    check("ld7_WD3", WD3, 32'h11);
    check("ld7_inflight_stall", 32'(stall), 32'd1);
    tick();
    check("ldx0_WE3", 32'(WE3), 32'd0);
    check("ldx0_WD3", WD3, 32'h22);
    check("ld7_done_stall", 32'(stall), 32'd0);
    rs2 = '0;

    // Starvation: one buffered load against continuous ALU traffic.
    ld_issue = 1'b1; ld_issue_rd = 5'd12;
    tick();
    ld_issue = 1'b0;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h33;
    tick();
    ld_rsp_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'h100 + 32'(i);
      check("starve_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      check("starve_alu_WD3", WD3, 32'h100 + 32'(i));
    end
    check("starve_blocked", 32'(alu_ready), 32'd0);
    alu_data = 32'h200;
    tick();
    check("starve_drain_AD3", 32'(AD3), 32'd12);
    check("starve_drain_WD3", WD3, 32'h33);
    check("starve_recover", 32'(alu_ready), 32'd1);
    tick();
    check("starve_alu_after", WD3, 32'h200);
    alu_valid = 1'b0;

    // Pending FIFO full, 5th issue dropped.
    rs1 = 5'd9;
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    for (int i = 0; i < 4; i++) tick();
    check("full_issue_ready", 32'(ld_issue_ready), 32'd0);
    check("full_err_clear", 32'(err), 32'd0);
    tick();
    ld_issue = 1'b0;
    check("overflow_err", 32'(err), 32'd1);
    check("overflow_still_full", 32'(ld_issue_ready), 32'd0);

    // Two buffered responses while the ALU holds the port.
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h77;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hA0;
    tick();
    ld_rsp_data = 32'hA1;
    tick();
    alu_valid = 1'b0; ld_rsp_valid = 1'b0;
    check("buf_full_rsp_ready", 32'(ld_rsp_ready), 32'd0);
    tick();
    check("drainA0_AD3", 32'(AD3), 32'd9);
    check("drainA0_WD3", WD3, 32'hA0);
    check("drainA0_issue_ready", 32'(ld_issue_ready), 32'd1);
    // Issue x9 while x9 drains.
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    check("drainA1_WD3", WD3, 32'hA1);
    check("same_rd_stall", 32'(stall), 32'd1);
    // Three more x9 loads remain: count stayed 4-1 after the cancelling pair.
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hB0;
    tick();
    ld_rsp_data = 32'hB1;
    tick();
    ld_rsp_data = 32'hB2;
    tick();
    ld_rsp_valid = 1'b0;
    check("drainB1_WD3", WD3, 32'hB1);
    check("drainB1_stall", 32'(stall), 32'd1);
    tick();
    check("drainB2_WD3", WD3, 32'hB2);
    check("drainB2_inflight_stall", 32'(stall), 32'd1);
    tick();
    check("x9_clear_stall", 32'(stall), 32'd0);
    rs1 = '0;

    // Response with nothing pending.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", 32'(err), 32'd0);
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hDEAD;
    tick();
    ld_rsp_valid = 1'b0;
    check("orphan_err", 32'(err), 32'd1);
    tick();
    check("orphan_no_write", 32'(WE3), 32'd0);
    tick();
    check("orphan_err_sticky", 32'(err), 32'd1);

    // Reset mid-operation drops queued loads.
    ld_issue = 1'b1; ld_issue_rd = 5'd4; rs1 = 5'd4;
    tick();
    ld_issue = 1'b0;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h44;
    tick();
    ld_rsp_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    tick();
    check("midrst_no_write", 32'(WE3), 32'd0);
    tick();
    rs1 = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
